// File: rtl/mux_seq_pkg.sv
// ============================================================================
// Module  : mux_seq_pkg
// Brief   : Shared types and constants for the mux select sequencer.
//           MUX_SEQ_MSB_FIRST_EN selects MSB-first (sel counts 7..0)
//           instead of the default LSB-first order (sel counts 0..7).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_seq_pkg;

  // Sequencer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } mux_state_e;

  // Width of the 8:1 mux select
  localparam int SEL_W = 3;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_SEL = 3'd7;
  localparam logic [SEL_W-1:0] LAST_SEL  = 3'd0;
  localparam logic             SEL_DOWN  = 1'b1;
`else
  localparam logic [SEL_W-1:0] FIRST_SEL = 3'd0;
  localparam logic [SEL_W-1:0] LAST_SEL  = 3'd7;
  localparam logic             SEL_DOWN  = 1'b0;
`endif

  // One select step in the configured direction
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s,
                                                input logic             down);
    logic [SEL_W-1:0] one;
    one = {{(SEL_W-1){1'b0}}, 1'b1};
    return down ? (s - one) : (s + one);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sel_step_counter.sv
// ============================================================================
// Module  : sel_step_counter
// Brief   : Select-width load/enable counter stepping in the direction fixed
//           by the package (up by default, down when MUX_SEQ_MSB_FIRST_EN is
//           defined). Flags when the count sits on the terminal value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sel_step_counter
  import mux_seq_pkg::*;
#(
  parameter logic [SEL_W-1:0] RST_VAL  = '0,
  parameter logic [SEL_W-1:0] TERM_VAL = LAST_SEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [SEL_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_cnt,
  output logic             o_term
);

  logic [SEL_W-1:0] r_cnt;

  // Load has priority over stepping; reset returns to the idle select value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= sel_step(r_cnt, SEL_DOWN);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == TERM_VAL);

endmodule

`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
// ============================================================================
// Module  : mux_sel_sequencer
// Brief   : Accepts a byte, then steps an 8:1 mux select through all eight
//           bit positions with a valid/ready handshake per bit. Counts fully
//           serialized bytes. MUX_SEQ_MSB_FIRST_EN switches to MSB-first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter logic [2:0] IDLE_SEL = 3'd0,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_in_data,
  output logic [7:0]       o_data,
  output logic [2:0]       o_sel,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last,
  output logic [CNT_W-1:0] o_bytes_done
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_SHIFT = SHIFT;

  logic [0:0]       r_state;
  logic [7:0]       r_data;
  logic [CNT_W-1:0] r_bytes_done;

  logic             w_accept;
  logic             w_xfer;
  logic             w_last;
  logic             w_done;
  logic             w_sel_load;
  logic [SEL_W-1:0] w_sel_load_val;
  logic             w_sel_en;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_term;

  // Handshake decode: accept only while idle, one bit transfer per ready cycle
  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign w_xfer   = o_out_valid && i_out_ready;
  assign w_last   = o_out_valid && w_sel_term;
  assign w_done   = w_xfer && w_last;

  // Select load on accept (first bit) or on the final transfer (back to idle)
  assign w_sel_load     = w_accept || w_done;
  assign w_sel_load_val = w_accept ? FIRST_SEL : IDLE_SEL;
  assign w_sel_en       = w_xfer && !w_last;

  sel_step_counter #(
    .RST_VAL  (IDLE_SEL),
    .TERM_VAL (LAST_SEL)
  ) u_sel_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_sel_load),
    .i_load_val (w_sel_load_val),
    .i_en       (w_sel_en),
    .o_cnt      (w_sel),
    .o_term     (w_sel_term)
  );

  // Two-state sequencer: IDLE waits for a byte, SHIFT walks the eight bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_state <= S_SHIFT;
        S_SHIFT: if (w_done)   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte register only loads in IDLE, so the mux data is frozen while shifting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= 8'h00;
    end else if (w_accept) begin
      r_data <= i_in_data;
    end
  end

  // Completed-byte counter; wraps naturally, untouched by aborted bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bytes_done <= '0;
    end else if (w_done) begin
      r_bytes_done <= r_bytes_done + CNT_W'(1);
    end
  end

  assign o_in_ready   = (r_state == S_IDLE);
  assign o_out_valid  = (r_state == S_SHIFT);
  assign o_out_last   = w_last;
  assign o_sel        = w_sel;
  assign o_data       = r_data;
  assign o_bytes_done = r_bytes_done;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
// ============================================================================
// Module  : tb_mux_sel_sequencer
// Brief   : Self-checking bench for mux_sel_sequencer. Honours
//           MUX_SEQ_MSB_FIRST_EN for the expected select order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_sel_sequencer;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [2:0] T_FIRST = 3'd7;
  localparam logic [2:0] T_LAST  = 3'd0;
  localparam logic [2:0] T_STEP  = 3'd7;
`else
  localparam logic [2:0] T_FIRST = 3'd0;
  localparam logic [2:0] T_LAST  = 3'd7;
  localparam logic [2:0] T_STEP  = 3'd1;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready,  in_ready2;
  logic [7:0] data,      data2;
  logic [2:0] sel,       sel2;
  logic       out_valid, out_valid2;
  logic       out_last,  out_last2;
  logic [7:0] bytes_done;
  logic [1:0] bytes_done2;

  int         n_pass;
  int         n_total;
  logic [7:0] exp_done;

  mux_sel_sequencer #(.IDLE_SEL(3'd0), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .o_data       (data),
    .o_sel        (sel),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_last   (out_last),
    .o_bytes_done (bytes_done)
  );

  mux_sel_sequencer #(.IDLE_SEL(3'd5), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready2),
    .i_in_data    (in_data),
    .o_data       (data2),
    .o_sel        (sel2),
    .o_out_valid  (out_valid2),
    .i_out_ready  (out_ready),
    .o_out_last   (out_last2),
    .o_bytes_done (bytes_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Send one byte; toggle=1 alternates out_ready starting with 1 on the accept cycle
  task automatic run_byte(input logic [7:0] din, input bit toggle, input int exp_cyc);
    int         cyc;
    logic [2:0] es;
    logic [7:0] d;
    bit         rdy;
    chk("idle_in_ready",  {31'd0, in_ready},  32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_out_last",  {31'd0, out_last},  32'd0);
    chk("idle_sel",       {29'd0, sel},       32'd0);
    in_valid  = 1'b1;
    in_data   = din;
    rdy       = 1'b1;
    out_ready = rdy;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    cyc = 0;
    es  = T_FIRST;
    while (out_valid && cyc < 40) begin
      d = data;
      chk("shift_in_ready", {31'd0, in_ready}, 32'd0);
      chk("shift_data",     {24'd0, data},     {24'd0, din});
      chk("shift_sel",      {29'd0, sel},      {29'd0, es});
      chk("mux_bit",        {31'd0, d[sel]},   {31'd0, din[es]});
      chk("out_last",       {31'd0, out_last}, {31'd0, (es == T_LAST)});
      rdy       = toggle ? ~rdy : 1'b1;
      out_ready = rdy;
      if (rdy) es = es + T_STEP;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    exp_done  = exp_done + 8'd1;
    chk("shift_cycles",   cyc, exp_cyc);
    chk("bytes_done",     {24'd0, bytes_done}, {24'd0, exp_done});
    chk("end_in_ready",   {31'd0, in_ready},   32'd1);
    chk("end_sel",        {29'd0, sel},        32'd0);
  endtask

  typedef struct {
    logic [7:0] din;
    bit         toggle;
    int         exp_cyc;
  } vec_t;

  vec_t       vecs[5];
  logic [1:0] exp2[5];

  initial begin
    logic [2:0] es;
    int         cyc;

    vecs[0] = '{din: 8'hA5, toggle: 1'b0, exp_cyc: 8};
    vecs[1] = '{din: 8'h3C, toggle: 1'b1, exp_cyc: 16};
    vecs[2] = '{din: 8'h80, toggle: 1'b0, exp_cyc: 8};
    vecs[3] = '{din: 8'hFF, toggle: 1'b1, exp_cyc: 16};
    vecs[4] = '{din: 8'h01, toggle: 1'b0, exp_cyc: 8};
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd0; exp2[4] = 2'd1;

    n_pass = 0; n_total = 0; exp_done = 8'd0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_sel",        {29'd0, sel},        32'd0);
    chk("rst_data",       {24'd0, data},       32'd0);
    chk("rst_bytes_done", {24'd0, bytes_done}, 32'd0);
    chk("rst_sel_idle5",  {29'd0, sel2},       32'd5);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while the select sits on 4 in the middle of 8'hFF
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    es  = T_FIRST;
    cyc = 0;
    while (es != 3'd4 && cyc < 10) begin
      es = es + T_STEP;
      cyc++;
      @(negedge clk);
    end
    chk("pre_rst_sel", {29'd0, sel}, 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("midrst_sel",        {29'd0, sel},        32'd0);
    chk("midrst_data",       {24'd0, data},       32'd0);
    chk("midrst_bytes_done", {24'd0, bytes_done}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);

    // Table-driven bytes
    for (int i = 0; i < 5; i++) run_byte(vecs[i].din, vecs[i].toggle, vecs[i].exp_cyc);

    // Back-to-back offer: second byte only taken in IDLE, 9 cycles after the first
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    chk("b2b_first_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_data = 8'h22;
    for (int k = 1; k <= 8; k++) begin
      chk("b2b_shift_in_ready", {31'd0, in_ready}, 32'd0);
      chk("b2b_data_held",      {24'd0, data},     32'h11);
      @(negedge clk);
    end
    exp_done = exp_done + 8'd1;
    chk("b2b_idle_in_ready",  {31'd0, in_ready},   32'd1);
    chk("b2b_idle_out_valid", {31'd0, out_valid},  32'd0);
    chk("b2b_bytes_done1",    {24'd0, bytes_done}, {24'd0, exp_done});
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_second_data",  {24'd0, data},      32'h22);
    chk("b2b_second_sel",   {29'd0, sel},       {29'd0, T_FIRST});
    cyc = 0;
    while (out_valid && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    exp_done = exp_done + 8'd1;
    chk("b2b_second_cycles", cyc, 8);
    chk("b2b_bytes_done2",   {24'd0, bytes_done}, {24'd0, exp_done});
    out_ready = 1'b0;

    // Narrow counter wrap: 5 bytes on a 2-bit counter
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; exp_done = 8'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      run_byte(8'h5A + 8'(i), 1'b0, 8);
      chk("cntw2_bytes_done", {30'd0, bytes_done2}, {30'd0, exp2[i]});
      chk("cntw2_idle_sel",   {29'd0, sel2},        32'd5);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 SHALL have parameter IDLE_SEL, default 3'd0: sel value driven while idle.
REQ-002 SHALL have parameter CNT_W, default 8: width of the completed-byte counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; the one clock, with reset synchronous and active-low.
REQ-005 in_valid  input  1  upstream byte offered.
REQ-006 in_ready  output  1  block accepts a byte this cycle.
REQ-007 in_data  input  8  byte to serialize.
REQ-008 data  output  8  latched byte, drives the 8:1 mux data input.
REQ-009 sel  output  3  bit index, drives the 8:1 mux select.
REQ-010 out_valid  output  1  sel/data pair is valid for downstream sampling of the mux output.
REQ-011 out_ready  input  1  downstream consumed the current bit.
REQ-012 out_last  output  1  current bit is the final bit of the byte.
REQ-013 bytes_done  output  CNT_W  count of fully serialized bytes.

Function
REQ-014 SHALL implement two states, IDLE and SHIFT, in a registered state machine.
REQ-015 In IDLE: in_ready=1, out_valid=0, out_last=0, and sel=IDLE_SEL; data holds the last latched byte.
REQ-016 Accept in IDLE on in_valid&&in_ready: data<=in_data, sel<=FIRST_SEL, state<=SHIFT; out_valid=1 from the next cycle (1-cycle load latency).
REQ-017 In SHIFT: in_ready=0; in_valid SHALL be ignored, and upstream holds its byte.
REQ-018 In SHIFT, bit transfer on out_valid&&out_ready advances sel by one step (+1, or -1 per REQ-026); with out_ready=0, sel, data and out_valid SHALL hold unchanged.
REQ-019 out_last SHALL be combinational: out_valid && (sel==LAST_SEL).
REQ-020 On transfer with out_last=1: state<=IDLE, sel<=IDLE_SEL, bytes_done<=bytes_done+1; bytes_done wraps from all-ones to 0.
REQ-021 Minimum throughput is 9 cycles per byte: 1 load cycle plus 8 bit cycles; no back-to-back accept on the last-bit cycle.
REQ-022 data SHALL NOT change in SHIFT; the mux output stays glitch-free within a byte except for sel steps.
REQ-023 sel SHALL never wrap past LAST_SEL within a byte.

Reset
REQ-024 When rst_n=0 at a clk edge: state=IDLE, data=8'h00, sel=IDLE_SEL, out_valid=0, bytes_done=0; in_ready=1 from the first cycle after rst_n deasserts.
REQ-025 Reset mid-SHIFT SHALL discard the in-flight byte without incrementing bytes_done; there is no partial-byte output after reset.

Configuration
REQ-026 Macro MUX_SEQ_MSB_FIRST_EN: when defined, FIRST_SEL=7, LAST_SEL=0, and sel decrements; when undefined, FIRST_SEL=0, LAST_SEL=7, and sel increments. All other behaviour is identical.

Structure
REQ-027 Shared package mux_seq_pkg SHALL hold the state enum (IDLE, SHIFT), FIRST_SEL/LAST_SEL constants selected by the macro, and the sel width constant.
REQ-028 One sub-module, sel_step_counter, is natural: a 3-bit load/enable up-or-down counter with a terminal flag. The top level holds the FSM, the data register and bytes_done.

Verification
REQ-029 Reset, then in_valid=1 with in_data=8'hA5 and out_ready=1 constantly -> LSB-first sel 0..7 over 8 cycles, mux bits 1,0,1,0,0,1,0,1, out_last only at sel=7, bytes_done=1, in_ready=1 on cycle 10.
REQ-030 Byte 8'h3C with out_ready toggling 1,0,1,0... -> sel advances only on ready cycles, data stable, 16 cycles in SHIFT, bytes_done+1.
REQ-031 Assert rst_n=0 at sel=4 during 8'hFF -> next cycle out_valid=0, sel=IDLE_SEL, data=8'h00, bytes_done unchanged at 0.
REQ-032 in_valid held high with 8'h11 then 8'h22 back-to-back -> second byte accepted only in IDLE, exactly 9 cycles after the first accept; in_ready=0 throughout SHIFT.
REQ-033 Build with MUX_SEQ_MSB_FIRST_EN, byte 8'h80 -> sel 7..0, first bit 1, out_last at sel=0.
REQ-034 CNT_W=2, 5 bytes sent -> bytes_done sequence 1,2,3,0,1.
